// File: rtl/arb_pkg.sv
// Shared types and widths for the L2 line arbiter.
package arb_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner select: a lone requester wins; on a conflict the port
// that was not granted last wins (a pointer tied to PORT_A gives B priority).
module arb_grant_sel
  import arb_pkg::*;
(
  input  logic      req_a,
  input  logic      req_b,
  input  arb_port_t last_grant,
  output arb_port_t winner
);

  always_comb begin
    winner = PORT_B;
    if (req_a && !req_b) begin
      winner = PORT_A;
    end else if (req_a && req_b && (last_grant == PORT_B)) begin
      winner = PORT_A;
    end
  end

endmodule

// File: rtl/l2_line_arbiter.sv
// Two-port line arbiter (I-side A, D-side B) onto one L2 request port.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is B over A.
//
// state   | meaning
// IDLE    | no downstream command outstanding, may grant
// SERVE_A | port A command on mem_*, waiting for mem_resp
// SERVE_B | port B command on mem_*, waiting for mem_resp
module l2_line_arbiter
  import arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [LINE_W-1:0] a_wdata,
  output logic              a_resp,
  output logic [LINE_W-1:0] a_rdata,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [LINE_W-1:0] b_wdata,
  output logic              b_resp,
  output logic [LINE_W-1:0] b_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t state_q, state_d;
  arb_port_t  winner, last_q;
  logic       req_a, req_b, grant;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;
  assign grant = (state_q == IDLE) && (req_a || req_b);

  arb_grant_sel u_grant_sel (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_q),
    .winner     (winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_A;
    end else if (grant) begin
      last_q <= winner;
    end
  end
`else
  assign last_q = PORT_A;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = (winner == PORT_A) ? SERVE_A : SERVE_B;
      SERVE_A: if (mem_resp) state_d = IDLE;
      SERVE_B: if (mem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command registers load only on a grant, so they are frozen during SERVE.
  // Read together with write is taken as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else if (grant) begin
      if (winner == PORT_A) begin
        mem_read    <= a_read & ~a_write;
        mem_write   <= a_write;
        mem_address <= a_address;
        mem_wdata   <= a_wdata;
      end else begin
        mem_read    <= b_read & ~b_write;
        mem_write   <= b_write;
        mem_address <= b_address;
        mem_wdata   <= b_wdata;
      end
    end else if ((state_q != IDLE) && mem_resp) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  always_comb begin
    busy    = (state_q == SERVE_A) || (state_q == SERVE_B);
    a_resp  = (state_q == SERVE_A) && mem_resp;
    b_resp  = (state_q == SERVE_B) && mem_resp;
    a_rdata = mem_rdata;
    b_rdata = mem_rdata;
  end

endmodule
